// File: rtl/vscale_htif_mon_pkg.sv
// Shared types and constants for the vscale HTIF tohost monitor:
// channel FSM states, per-hart result encoding and the default tohost CSR address.
package vscale_htif_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CLR_REQ,
    CLR_WAIT,
    GAP,
    RESULT
  } chan_state_e;

  // Outcome a channel reports to the aggregator once it reaches RESULT.
  typedef enum logic [1:0] {
    RES_NONE,
    RES_PASS,
    RES_FAIL
  } result_e;

  localparam logic [11:0] TOHOST_ADDR_DEFAULT = 12'h780;
  localparam int unsigned TOHOST_PASS_VAL     = 1;

endpackage

// File: rtl/vscale_htif_poll_chan.sv
// One HTIF PCR polling channel: reads tohost until it is nonzero, then holds the value.
// HTIF_TOHOST_CLEAR_EN adds a write of 0 to tohost before the channel reports its result.
module vscale_htif_poll_chan
  import vscale_htif_mon_pkg::*;
#(
  parameter int PCR_WIDTH = 64,
  parameter int POLL_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 stop,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic                 req_rw,
  input  logic                 resp_valid,
  output logic                 resp_ready,
  input  logic [PCR_WIDTH-1:0] resp_data,
  output result_e              result,
  output logic [PCR_WIDTH-2:0] code
);

  localparam int GW = $clog2(POLL_GAP + 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  chan_state_e          state_q, state_d;
  logic [PCR_WIDTH-1:0] val_q, val_d;
  logic [GW-1:0]        gap_q, gap_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    gap_d      = gap_q;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    resp_ready = 1'b0;
    result     = RES_NONE;
    case (state_q)
      IDLE: if (enable && !stop) state_d = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = WAIT;
      end
      WAIT: begin
        resp_ready = 1'b1;
        if (resp_valid) begin
          if (resp_data == '0) begin
            gap_d   = '0;
            state_d = (POLL_GAP > 0) ? GAP : IDLE;
          end else begin
            val_d = resp_data;
`ifdef HTIF_TOHOST_CLEAR_EN
            state_d = CLR_REQ;
`else
            state_d = RESULT;
`endif
          end
        end
      end
`ifdef HTIF_TOHOST_CLEAR_EN
      CLR_REQ: begin
        req_valid = 1'b1;
        req_rw    = 1'b1;
        if (req_ready) state_d = CLR_WAIT;
      end
      CLR_WAIT: begin
        resp_ready = 1'b1;
        if (resp_valid) state_d = RESULT;
      end
`endif
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = IDLE;
      end
      // Terminal: the latched value decides pass vs fail for this hart.
      RESULT: result = (val_q == PCR_WIDTH'(TOHOST_PASS_VAL)) ? RES_PASS : RES_FAIL;
      default: state_d = IDLE;
    endcase
  end

  assign code = val_q[PCR_WIDTH-1:1];

endmodule

// File: rtl/vscale_htif_tohost_monitor.sv
// Multi-hart HTIF tohost poller: per-hart channels, sticky pass/fail/timeout status and watchdog.
// Define HTIF_TOHOST_CLEAR_EN to have each channel clear tohost after a nonzero read.
module vscale_htif_tohost_monitor
  import vscale_htif_mon_pkg::*;
#(
  parameter int                    NUM_HARTS   = 1,
  parameter int                    PCR_WIDTH   = 64,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(TOHOST_ADDR_DEFAULT),
  parameter int                    POLL_GAP    = 4,
  localparam int                   HW          = $clog2(NUM_HARTS) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [63:0]                     max_cycles,
  output logic [NUM_HARTS-1:0]            htif_pcr_req_valid,
  input  logic [NUM_HARTS-1:0]            htif_pcr_req_ready,
  output logic [NUM_HARTS-1:0]            htif_pcr_req_rw,
  output logic [NUM_HARTS*ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [NUM_HARTS*PCR_WIDTH-1:0]  htif_pcr_req_data,
  input  logic [NUM_HARTS-1:0]            htif_pcr_resp_valid,
  output logic [NUM_HARTS-1:0]            htif_pcr_resp_ready,
  input  logic [NUM_HARTS*PCR_WIDTH-1:0]  htif_pcr_resp_data,
  output logic                            done,
  output logic                            pass,
  output logic                            fail,
  output logic                            timeout,
  output logic [HW-1:0]                   fail_hart,
  output logic [PCR_WIDTH-2:0]            fail_code,
  output logic [63:0]                     cycle_count
);

  result_e              res  [NUM_HARTS];
  logic [PCR_WIDTH-2:0] code [NUM_HARTS];

  logic                 pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
  logic [HW-1:0]        fail_hart_q, fail_hart_d;
  logic [PCR_WIDTH-2:0] fail_code_q, fail_code_d;
  logic [63:0]          cnt_q, cnt_d;

  logic                 any_fail, all_pass;
  logic [HW-1:0]        first_hart;
  logic [PCR_WIDTH-2:0] first_code;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_chan
    vscale_htif_poll_chan #(
      .PCR_WIDTH (PCR_WIDTH),
      .POLL_GAP  (POLL_GAP)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .stop       (done),
      .req_valid  (htif_pcr_req_valid[h]),
      .req_ready  (htif_pcr_req_ready[h]),
      .req_rw     (htif_pcr_req_rw[h]),
      .resp_valid (htif_pcr_resp_valid[h]),
      .resp_ready (htif_pcr_resp_ready[h]),
      .resp_data  (htif_pcr_resp_data[h*PCR_WIDTH +: PCR_WIDTH]),
      .result     (res[h]),
      .code       (code[h])
    );
    assign htif_pcr_req_addr[h*ADDR_WIDTH +: ADDR_WIDTH] = TOHOST_ADDR;
  end

  assign htif_pcr_req_data = '0;

  // Scan high to low so the lowest failing hart is the one left standing.
  always_comb begin
    any_fail   = 1'b0;
    all_pass   = 1'b1;
    first_hart = '0;
    first_code = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (res[h] == RES_FAIL) begin
        any_fail   = 1'b1;
        first_hart = HW'(h);
        first_code = code[h];
      end
      if (res[h] != RES_PASS) all_pass = 1'b0;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_hart_d = fail_hart_q;
    fail_code_d = fail_code_q;
    if (enable && !done && cnt_q != '1) cnt_d = cnt_q + 64'd1;
    // Priority fail > pass > timeout lets a result beat a same-cycle expiry.
    if (!done) begin
      if (any_fail) begin
        fail_d      = 1'b1;
        fail_hart_d = first_hart;
        fail_code_d = first_code;
      end else if (all_pass) begin
        pass_d = 1'b1;
      end else if (max_cycles != '0 && cnt_d >= max_cycles) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_hart_q <= '0;
      fail_code_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_hart_q <= fail_hart_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign done        = pass_q | fail_q | timeout_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_hart   = fail_hart_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// Randomized bench for vscale_htif_tohost_monitor (2 harts): protocol-level HTIF responders
// plus an outcome model built from per-hart tohost scripts.
module tb_vscale_htif_tohost_monitor;

  localparam int NH  = 2;
  localparam int PW  = 64;
  localparam int AW  = 12;
  localparam int HWB = $clog2(NH) + 1;
  localparam logic [AW-1:0] TADDR = 12'h780;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic [63:0]       max_cycles;
  logic [NH-1:0]     req_valid, req_ready, req_rw, resp_valid, resp_ready;
  logic [NH*AW-1:0]  req_addr;
  logic [NH*PW-1:0]  req_data, resp_data;
  logic              done, pass, fail, timeout;
  logic [HWB-1:0]    fail_hart;
  logic [PW-2:0]     fail_code;
  logic [63:0]       cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vscale_htif_tohost_monitor #(
    .NUM_HARTS   (NH),
    .PCR_WIDTH   (PW),
    .ADDR_WIDTH  (AW),
    .TOHOST_ADDR (TADDR),
    .POLL_GAP    (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .max_cycles          (max_cycles),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .fail                (fail),
    .timeout             (timeout),
    .fail_hart           (fail_hart),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  // Per-hart tohost scripts: successive read values; the last entry repeats.
  logic [PW-1:0] scr [NH][8];
  int            slen [NH];
  int            sidx [NH];
  bit            pend [NH], pend_rw [NH], hclr [NH], hres [NH], wr_seen [NH];
  logic [PW-1:0] hval [NH];
  bit            prev_vld [NH], prev_acc [NH], prev_rw [NH];
  int            stall [NH], held [NH];
  bit            prev_en, prev_done, det, en_rand;
  bit            m_done, m_pass, m_fail, m_to;
  int            m_hart;
  logic [PW-2:0] m_code;
  logic [63:0]   m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      sidx[h] = 0; pend[h] = 0; pend_rw[h] = 0; hclr[h] = 0; hres[h] = 0;
      hval[h] = '0; wr_seen[h] = 0; prev_vld[h] = 0; prev_acc[h] = 0;
      prev_rw[h] = 0; stall[h] = 0; held[h] = 0;
    end
    prev_en = 0; prev_done = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_hart = 0; m_code = '0; m_cnt = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; req_ready = '0; resp_valid = '0; resp_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_scr(input int h, input int n, input logic [PW-1:0] v0, v1, v2, v3);
    slen[h] = n;
    scr[h][0] = v0; scr[h][1] = v1; scr[h][2] = v2; scr[h][3] = v3;
  endtask

  // Called at a negedge: check outputs against the model, drive the next inputs,
  // and advance the model to what must hold after the coming posedge.
  task automatic step();
    int            lowest;
    bit            all_p, rv, qrdy, qhs;
    logic [63:0]   cnt_n;
    logic [PW-1:0] rd;
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("timeout", timeout, m_to);
    chk("cycle_count", cycle_count, m_cnt);
    if (m_fail) begin
      chk("fail_hart", fail_hart, m_hart);
      chk("fail_code", fail_code, m_code);
    end
    for (int h = 0; h < NH; h++) begin
      chk("resp_ready", resp_ready[h], pend[h]);
      if (hres[h]) chk("req_after_result", req_valid[h], 0);
      if (prev_vld[h] && !prev_acc[h])
        chk("req_hold", {req_valid[h], req_rw[h]}, {1'b1, prev_rw[h]});
      else if (req_valid[h] && !prev_vld[h] && !hclr[h])
        chk("req_start_gate", prev_en && !prev_done, 1);
      if (req_valid[h]) begin
        chk("req_addr", req_addr[h*AW +: AW], TADDR);
        chk("req_data", req_data[h*PW +: PW], 0);
        chk("req_rw", req_rw[h], hclr[h]);
      end
    end
    if (en_rand) enable = ($urandom_range(0, 7) != 0);
    lowest = -1;
    all_p  = 1;
    for (int h = 0; h < NH; h++) begin
      if (hres[h] && hval[h] != 1 && lowest < 0) lowest = h;
      if (!(hres[h] && hval[h] == 1)) all_p = 0;
    end
    cnt_n = (enable && !m_done && m_cnt != '1) ? m_cnt + 64'd1 : m_cnt;
    prev_done = m_done;
    prev_en   = enable;
    if (!m_done) begin
      if (lowest >= 0) begin
        m_fail = 1; m_hart = lowest; m_code = (PW-1)'(hval[lowest] >> 1);
      end else if (all_p) begin
        m_pass = 1;
      end else if (max_cycles != 0 && cnt_n >= max_cycles) begin
        m_to = 1;
      end
    end
    m_done = m_pass | m_fail | m_to;
    m_cnt  = cnt_n;
    for (int h = 0; h < NH; h++) begin
      if (pend[h]) begin
        rv = det || ($urandom_range(0, 2) != 0);
        rd = pend_rw[h] ? '0 : scr[h][(sidx[h] < slen[h]) ? sidx[h] : slen[h] - 1];
      end else begin
        rv = !det && ($urandom_range(0, 3) == 0);
        rd = 64'h55;
      end
      resp_valid[h] = rv;
      resp_data[h*PW +: PW] = rd;
      qrdy = (stall[h] > 0) ? 1'b0 : (det || $urandom_range(0, 1) == 1);
      if (stall[h] > 0) begin
        stall[h]--;
        if (req_valid[h]) held[h]++;
      end
      req_ready[h] = qrdy;
      if (pend[h] && rv) begin
        pend[h] = 0;
        if (pend_rw[h]) begin
          hclr[h] = 0; hres[h] = 1;
        end else begin
          sidx[h]++;
          if (rd != 0) begin
            hval[h] = rd;
`ifdef HTIF_TOHOST_CLEAR_EN
            hclr[h] = 1;
`else
            hres[h] = 1;
`endif
          end
        end
      end
      qhs = req_valid[h] && qrdy;
      if (qhs) begin
        pend[h] = 1; pend_rw[h] = req_rw[h];
        if (req_rw[h]) wr_seen[h] = 1;
      end
      prev_vld[h] = req_valid[h];
      prev_acc[h] = qhs;
      prev_rw[h]  = req_rw[h];
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (!(m_done && !pend[0] && !pend[1] && req_valid == '0) && n < budget) begin
      step();
      @(negedge clk);
      n++;
    end
    chk("finished_in_budget", done, 1);
    repeat (8) begin
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; max_cycles = '0; det = 0; en_rand = 0;
    req_ready = '0; resp_valid = '0; resp_data = '0;
    model_reset();
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_status", {pass, fail, timeout}, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_addr", req_addr, {TADDR, TADDR});

    // 0,0,0 then pass on hart 0
    do_reset();
    set_scr(0, 4, 0, 0, 0, 1); set_scr(1, 1, 1, 0, 0, 0); enable = 1;
    run(2000);
    chk("s1_pass", pass, 1); chk("s1_fail", fail, 0); chk("s1_timeout", timeout, 0);
    chk("s1_reads", sidx[0], 4);

    // 0x2B on hart 0
    do_reset();
    set_scr(0, 1, 64'h2B, 0, 0, 0); set_scr(1, 1, 1, 0, 0, 0); enable = 1;
    run(2000);
    chk("s2_fail", fail, 1); chk("s2_code", fail_code, 21); chk("s2_hart", fail_hart, 0);
    chk("s2_pass", pass, 0);

    // watchdog
    do_reset();
    set_scr(0, 1, 0, 0, 0, 0); set_scr(1, 1, 0, 0, 0, 0); max_cycles = 50; enable = 1;
    run(2000);
    chk("s3_timeout", timeout, 1); chk("s3_count", cycle_count, 50);
    chk("s3_idle", req_valid, 0); chk("s3_fail", fail, 0);
    max_cycles = 0;

    // hart1 fails with 7
    do_reset();
    set_scr(0, 1, 1, 0, 0, 0); set_scr(1, 1, 7, 0, 0, 0); enable = 1;
    run(2000);
    chk("s4_fail", fail, 1); chk("s4_hart", fail_hart, 1); chk("s4_code", fail_code, 3);

    // both fail in the same cycle: lowest hart wins
    do_reset();
    det = 1;
    set_scr(0, 1, 5, 0, 0, 0); set_scr(1, 1, 9, 0, 0, 0); enable = 1;
    run(2000);
    chk("s4b_hart", fail_hart, 0); chk("s4b_code", fail_code, 2);
    det = 0;

    // req_ready held low
    do_reset();
    set_scr(0, 1, 1, 0, 0, 0); set_scr(1, 1, 1, 0, 0, 0); stall[0] = 14; enable = 1;
    run(2000);
    chk("s5_reads", sidx[0], 1); chk("s5_held", held[0] >= 10, 1); chk("s5_pass", pass, 1);

    // reset while hart 0 waits for a response
    do_reset();
    set_scr(0, 2, 0, 1, 0, 0); set_scr(1, 1, 1, 0, 0, 0); enable = 1;
    for (int n = 0; n < 200 && !pend[0]; n++) begin
      step();
      @(negedge clk);
    end
    chk("s6_in_wait", resp_ready[0], 1);
    reset = 1'b1;
    #1;
    chk("s6_rst_status", {done, pass, fail, timeout}, 0);
    chk("s6_rst_count", cycle_count, 0);
    chk("s6_rst_req", {req_valid, req_rw, resp_ready}, 0);
    chk("s6_rst_fail_info", {fail_hart, fail_code}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    run(2000);
    chk("s6_pass", pass, 1); chk("s6_reads", sidx[0], 2);

`ifdef HTIF_TOHOST_CLEAR_EN
    do_reset();
    set_scr(0, 1, 3, 0, 0, 0); set_scr(1, 1, 1, 0, 0, 0); enable = 1;
    run(2000);
    chk("clr_fail", fail, 1); chk("clr_write_seen", wr_seen[0], 1); chk("clr_code", fail_code, 1);
`endif

    // randomized scripts, watchdog limits and enable toggling
    for (int it = 0; it < 8; it++) begin
      do_reset();
      for (int h = 0; h < NH; h++) begin
        int nz = $urandom_range(0, 4);
        for (int k = 0; k < nz; k++) scr[h][k] = '0;
        scr[h][nz] = ($urandom_range(0, 2) != 0) ? 64'd1 : ({$urandom, $urandom} | 64'h2);
        slen[h] = nz + 1;
      end
      max_cycles = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(20, 120)) : 64'd0;
      en_rand = 1;
      enable  = 1;
      run(3000);
      en_rand = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
